// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel path: colour-depth codes, widths,
// 24bpp phase encoding and the RGB565 to RGB888 expansion.
package vga_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned RGB_W  = 24;
    localparam int unsigned RES_W  = 16;

    localparam logic [1:0] CD_8BPP  = 2'b00;
    localparam logic [1:0] CD_16BPP = 2'b01;
    localparam logic [1:0] CD_24BPP = 2'b10;
    localparam logic [1:0] CD_32BPP = 2'b11;

    // Position within the 3-word / 4-pixel 24bpp group
    typedef enum logic [1:0] {
        PH_0 = 2'd0,
        PH_1 = 2'd1,
        PH_2 = 2'd2
    } phase_t;

    // Widen 5/6/5 fields by replicating their MSBs into the new LSBs
    function automatic logic [RGB_W-1:0] rgb565_to_888(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

endpackage

// File: rtl/vga_rgb_expand.sv
// Combinational conversion of a raw pixel field to 24-bit RGB.
// Ports:
//   cd    : colour depth code (vga_pkg CD_*)
//   raw   : raw pixel field, right-aligned (8, 16 or 24 significant bits)
//   rgb_c : {R,G,B} 8 bits each
module vga_rgb_expand
    import vga_pkg::*;
(
    input  logic [1:0]       cd,
    input  logic [RGB_W-1:0] raw,
    output logic [RGB_W-1:0] rgb_c
);

    always_comb begin
        rgb_c = raw;
        case (cd)
            CD_8BPP:  rgb_c = {3{raw[7:0]}};
            CD_16BPP: rgb_c = rgb565_to_888(raw[15:0]);
            default:  rgb_c = raw;
        endcase
    end

endmodule

// File: rtl/vga_pixel_unpacker.sv
// Unpacks 32-bit video-memory words into 24-bit RGB pixels, one per clock,
// feeding the line-FIFO write port. Supports 8bpp grey, 16bpp RGB565,
// 24bpp packed (3 words carry 4 pixels) and 32bpp.
// Optional feature macro: VGA_PIXUNPACK_CLUT_EN (8bpp pseudo-colour via CLUT).
// Ports:
//   wb_clk_i, rst_nreset_i : clock, async active-low reset
//   sync_clr_i             : synchronous frame-start clear
//   ctrl_cd_i, ctrl_pc_i   : colour depth, pseudo-colour select
//   dat_i/dat_valid_i/dat_ready_o : word input handshake
//   fifo_full_i            : line FIFO full (stalls emission)
//   pix_wreq_o, pix_o      : line-FIFO write strobe and RGB data
//   clut_req_o/clut_adr_o/clut_ack_i/clut_q_i : CLUT lookup port
module vga_pixel_unpacker
    import vga_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              wb_clk_i,
    input  logic              rst_nreset_i,
    input  logic              sync_clr_i,
    input  logic [1:0]        ctrl_cd_i,
    input  logic              ctrl_pc_i,
    input  logic [WORD_W-1:0] dat_i,
    input  logic              dat_valid_i,
    output logic              dat_ready_o,
    input  logic              fifo_full_i,
    output logic              pix_wreq_o,
    output logic [RGB_W-1:0]  pix_o,
    output logic              clut_req_o,
    output logic [7:0]        clut_adr_o,
    input  logic              clut_ack_i,
    input  logic [RGB_W-1:0]  clut_q_i
);

    logic [WORD_W-1:0] wbuf_q;
    logic              wbuf_vld_q;
    logic [1:0]        idx_q;
    phase_t            phase_q;
    logic [RES_W-1:0]  res_q;
    logic [1:0]        cd_q;
    logic              rdy_en_q;

    logic [RGB_W-1:0]  raw;
    logic [RGB_W-1:0]  rgb;
    logic [RGB_W-1:0]  pix_d;
    logic [RES_W-1:0]  res_d;
    logic              last;
    logic              emit;
    logic              grant;
    logic              clut_mode;
    logic              accept;
    logic [1:0]        lane8;
    logic              lane16;

    // Lane of the current pixel inside the buffered word
    assign lane8  = BIG_ENDIAN ? ~idx_q : idx_q;
    assign lane16 = BIG_ENDIAN ? ~idx_q[0] : idx_q[0];

    // Raw pixel field selection, last-pixel flag and next 24bpp residue
    always_comb begin
        raw   = '0;
        res_d = '0;
        last  = 1'b0;
        case (cd_q)
            CD_8BPP: begin
                raw  = {16'h0000, wbuf_q[{lane8, 3'b000} +: 8]};
                last = (idx_q == 2'd3);
            end
            CD_16BPP: begin
                raw  = {8'h00, wbuf_q[{lane16, 4'b0000} +: 16]};
                last = idx_q[0];
            end
            CD_24BPP: begin
                case (phase_q)
                    PH_0: begin
                        last = 1'b1;
                        if (BIG_ENDIAN) begin
                            raw   = wbuf_q[31:8];
                            res_d = {8'h00, wbuf_q[7:0]};
                        end else begin
                            raw   = wbuf_q[23:0];
                            res_d = {8'h00, wbuf_q[31:24]};
                        end
                    end
                    PH_1: begin
                        last = 1'b1;
                        if (BIG_ENDIAN) begin
                            raw   = {res_q[7:0], wbuf_q[31:16]};
                            res_d = wbuf_q[15:0];
                        end else begin
                            raw   = {wbuf_q[15:0], res_q[7:0]};
                            res_d = wbuf_q[31:16];
                        end
                    end
                    default: begin
                        // Third word of the group carries two pixels
                        last = idx_q[0];
                        if (BIG_ENDIAN) begin
                            raw = idx_q[0] ? wbuf_q[23:0] : {res_q, wbuf_q[31:24]};
                        end else begin
                            raw = idx_q[0] ? wbuf_q[31:8] : {wbuf_q[7:0], res_q};
                        end
                    end
                endcase
            end
            default: begin
                raw  = wbuf_q[23:0];
                last = 1'b1;
            end
        endcase
    end

    vga_rgb_expand u_expand (
        .cd    (cd_q),
        .raw   (raw),
        .rgb_c (rgb)
    );

`ifdef VGA_PIXUNPACK_CLUT_EN
    logic pc_q;

    assign clut_mode = (cd_q == CD_8BPP) && pc_q;
    assign grant     = clut_req_o && clut_ack_i;
    assign pix_d     = grant ? clut_q_i : rgb;

    // CLUT request: held until ack; full only blocks issuing, never a grant
    always_ff @(posedge wb_clk_i or negedge rst_nreset_i) begin
        if (!rst_nreset_i) begin
            pc_q       <= 1'b0;
            clut_req_o <= 1'b0;
            clut_adr_o <= 8'h00;
        end else if (sync_clr_i) begin
            clut_req_o <= 1'b0;
        end else begin
            if (!wbuf_vld_q && phase_q == PH_0) begin
                pc_q <= ctrl_pc_i;
            end
            if (grant) begin
                clut_req_o <= 1'b0;
            end else if (wbuf_vld_q && clut_mode && !clut_req_o && !fifo_full_i) begin
                clut_req_o <= 1'b1;
                clut_adr_o <= raw[7:0];
            end
        end
    end
`else
    logic unused_clut;

    assign clut_mode   = 1'b0;
    assign grant       = 1'b0;
    assign pix_d       = rgb;
    assign clut_req_o  = 1'b0;
    assign clut_adr_o  = 8'h00;
    assign unused_clut = ^{ctrl_pc_i, clut_ack_i, clut_q_i};
`endif

    // Direct pixels need FIFO room; CLUT pixels are written when granted
    assign emit        = (wbuf_vld_q && !fifo_full_i && !clut_mode) || grant;
    assign dat_ready_o = rdy_en_q && !sync_clr_i && (!wbuf_vld_q || (emit && last));
    assign accept      = dat_valid_i && dat_ready_o;

    // Word buffer, pixel index, 24bpp phase/residue and registered outputs
    always_ff @(posedge wb_clk_i or negedge rst_nreset_i) begin
        if (!rst_nreset_i) begin
            wbuf_q     <= '0;
            wbuf_vld_q <= 1'b0;
            idx_q      <= 2'd0;
            phase_q    <= PH_0;
            res_q      <= '0;
            cd_q       <= CD_8BPP;
            rdy_en_q   <= 1'b0;
            pix_wreq_o <= 1'b0;
            pix_o      <= '0;
        end else begin
            rdy_en_q   <= 1'b1;
            pix_wreq_o <= 1'b0;
            if (sync_clr_i) begin
                wbuf_vld_q <= 1'b0;
                idx_q      <= 2'd0;
                phase_q    <= PH_0;
                res_q      <= '0;
            end else begin
                // Depth only changes on a clean word boundary
                if (!wbuf_vld_q && phase_q == PH_0) begin
                    cd_q <= ctrl_cd_i;
                end
                if (emit) begin
                    pix_wreq_o <= 1'b1;
                    pix_o      <= pix_d;
                    if (last) begin
                        wbuf_vld_q <= 1'b0;
                        idx_q      <= 2'd0;
                        if (cd_q == CD_24BPP) begin
                            res_q <= res_d;
                            case (phase_q)
                                PH_0:    phase_q <= PH_1;
                                PH_1:    phase_q <= PH_2;
                                default: phase_q <= PH_0;
                            endcase
                        end
                    end else begin
                        idx_q <= idx_q + 2'd1;
                    end
                end
                if (accept) begin
                    wbuf_q     <= dat_i;
                    wbuf_vld_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_pixel_unpacker.sv
module tb_vga_pixel_unpacker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sync_clr = 1'b0;
    logic [1:0]  ctrl_cd = 2'd0;
    logic        ctrl_pc = 1'b0;
    logic [31:0] dat_i = 32'h0;
    logic        dat_valid_i = 1'b0;
    logic        dat_ready_o;
    logic        fifo_full_i = 1'b0;
    logic        pix_wreq_o;
    logic [23:0] pix_o;
    logic        clut_req_o;
    logic [7:0]  clut_adr_o;
    logic        clut_ack_i = 1'b0;
    logic [23:0] clut_q_i = 24'h0;

    always #5 clk = ~clk;

    vga_pixel_unpacker dut (
        .wb_clk_i     (clk),
        .rst_nreset_i (rst_n),
        .sync_clr_i   (sync_clr),
        .ctrl_cd_i    (ctrl_cd),
        .ctrl_pc_i    (ctrl_pc),
        .dat_i        (dat_i),
        .dat_valid_i  (dat_valid_i),
        .dat_ready_o  (dat_ready_o),
        .fifo_full_i  (fifo_full_i),
        .pix_wreq_o   (pix_wreq_o),
        .pix_o        (pix_o),
        .clut_req_o   (clut_req_o),
        .clut_adr_o   (clut_adr_o),
        .clut_ack_i   (clut_ack_i),
        .clut_q_i     (clut_q_i)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int viol = 0;
    int waits;
    int n;
    logic full_q = 1'b0;
    logic rand_full_en = 1'b0;
    logic force_full = 1'b0;
    logic [23:0] got_q[$];
    int          stamp_q[$];
    logic [23:0] exp_q[$];
    logic [31:0] wq[$];

    typedef struct packed {
        logic [1:0]       cd;
        logic             clr;
        logic [1:0]       nw;
        logic [2:0][31:0] w;
        logic [2:0]       np;
        logic [3:0][23:0] p;
    } vec_t;
    vec_t vt[7];

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        full_q <= fifo_full_i;
    end

    // Collect written pixels; drive the FIFO-full pattern
    always @(negedge clk) begin
        if (rst_n && pix_wreq_o) begin
            got_q.push_back(pix_o);
            stamp_q.push_back(cyc);
            if (full_q) viol++;
        end
        fifo_full_i = rand_full_en ? ($urandom_range(0, 9) < 3) : force_full;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w, output int nw);
        logic acc;
        acc = 1'b0;
        nw  = 0;
        while (!acc && nw < 300) begin
            @(negedge clk);
            dat_i       = w;
            dat_valid_i = 1'b1;
            #1;
            acc = dat_ready_o;
            nw++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: word %h not accepted", w);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        dat_valid_i = 1'b0;
    endtask

    task automatic clr();
        @(negedge clk);
        dat_valid_i = 1'b0;
        sync_clr    = 1'b1;
        @(negedge clk);
        sync_clr = 1'b0;
        got_q.delete();
        stamp_q.delete();
    endtask

    task automatic wait_got(input int cnt);
        int k;
        k = 0;
        while (got_q.size() < cnt && k < 400) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic expect_stream(input string name);
        wait_got(exp_q.size());
        repeat (6) @(negedge clk);
        chk({name, "_count"}, got_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < got_q.size()) chk($sformatf("%s_pix%0d", name, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        stamp_q.delete();
        exp_q.delete();
    endtask

    // Reference: words form a big-endian byte stream; pixels are taken from it
    task automatic build_exp(input logic [1:0] cd);
        logic [7:0] bq[$];
        int p, r5, g6, b5;
        foreach (wq[i]) for (int k = 3; k >= 0; k--) bq.push_back(8'(wq[i] >> (8 * k)));
        case (cd)
            2'd0: foreach (bq[i]) exp_q.push_back({bq[i], bq[i], bq[i]});
            2'd1: for (int i = 0; i + 1 < bq.size(); i += 2) begin
                p  = bq[i] * 256 + bq[i+1];
                r5 = p / 2048;
                g6 = (p / 32) % 64;
                b5 = p % 32;
                exp_q.push_back({8'(r5 * 8 + r5 / 4), 8'(g6 * 4 + g6 / 16), 8'(b5 * 8 + b5 / 4)});
            end
            2'd2: for (int i = 0; i + 2 < bq.size(); i += 3)
                exp_q.push_back({bq[i], bq[i+1], bq[i+2]});
            default: for (int i = 0; i + 3 < bq.size(); i += 4)
                exp_q.push_back({bq[i+1], bq[i+2], bq[i+3]});
        endcase
    endtask

    function automatic logic [23:0] clut_of(input logic [7:0] a);
        return (a == 8'h05) ? 24'h123456 : {a, ~a, 8'h5A};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{cd: 2'd0, clr: 1'b1, nw: 2'd1, w: {32'h0, 32'h0, 32'h11223344},
                  np: 3'd4, p: {24'h444444, 24'h333333, 24'h222222, 24'h111111}};
        vt[1] = '{cd: 2'd1, clr: 1'b1, nw: 2'd1, w: {32'h0, 32'h0, 32'hF80007E0},
                  np: 3'd2, p: {24'h0, 24'h0, 24'h00FF00, 24'hFF0000}};
        vt[2] = '{cd: 2'd1, clr: 1'b1, nw: 2'd1, w: {32'h0, 32'h0, 32'h001FFFFF},
                  np: 3'd2, p: {24'h0, 24'h0, 24'hFFFFFF, 24'h0000FF}};
        vt[3] = '{cd: 2'd2, clr: 1'b1, nw: 2'd3, w: {32'h22334455, 32'hEEFF0011, 32'hAABBCCDD},
                  np: 3'd4, p: {24'h334455, 24'h001122, 24'hDDEEFF, 24'hAABBCC}};
        vt[4] = '{cd: 2'd2, clr: 1'b0, nw: 2'd1, w: {32'h0, 32'h0, 32'h778899AA},
                  np: 3'd1, p: {24'h0, 24'h0, 24'h0, 24'h778899}};
        vt[5] = '{cd: 2'd3, clr: 1'b1, nw: 2'd1, w: {32'h0, 32'h0, 32'h12345678},
                  np: 3'd1, p: {24'h0, 24'h0, 24'h0, 24'h345678}};
        vt[6] = '{cd: 2'd0, clr: 1'b1, nw: 2'd1, w: {32'h0, 32'h0, 32'h00FF807F},
                  np: 3'd4, p: {24'h7F7F7F, 24'h808080, 24'hFFFFFF, 24'h000000}};

        // Reset values
        #2 rst_n = 1'b0;
        #3;
        chk("rst_wreq", pix_wreq_o, 0);
        chk("rst_pix", pix_o, 0);
        chk("rst_ready", dat_ready_o, 0);
        chk("rst_clut_req", clut_req_o, 0);
        chk("rst_clut_adr", clut_adr_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vectors
        foreach (vt[v]) begin
            ctrl_cd = vt[v].cd;
            if (vt[v].clr) clr();
            for (int i = 0; i < int'(vt[v].nw); i++) push_word(vt[v].w[i], waits);
            idle();
            for (int i = 0; i < int'(vt[v].np); i++) exp_q.push_back(vt[v].p[i]);
            expect_stream($sformatf("vec%0d", v));
        end

        // Back-to-back 8bpp words: ready on the 4th emit, no bubble
        ctrl_cd = 2'd0;
        clr();
        push_word(32'h11223344, waits);
        push_word(32'h55667788, waits);
        chk("b2b_ready_4th_emit", waits, 4);
        idle();
        wq.delete();
        wq.push_back(32'h11223344);
        wq.push_back(32'h55667788);
        build_exp(2'd0);
        wait_got(8);
        if (stamp_q.size() >= 8) chk("b2b_span", stamp_q[7] - stamp_q[0], 7);
        expect_stream("b2b");

        // 32bpp stream with FIFO full for 3 cycles mid-stream
        ctrl_cd = 2'd3;
        clr();
        wq.delete();
        for (int i = 0; i < 6; i++) wq.push_back(32'hA0000000 + i * 32'h00111111);
        build_exp(2'd3);
        fork
            begin
                foreach (wq[i]) push_word(wq[i], waits);
                idle();
            end
            begin
                repeat (3) @(negedge clk);
                #2 force_full = 1'b1;
                repeat (3) @(negedge clk);
                #2 force_full = 1'b0;
            end
        join
        expect_stream("stall32");
        chk("stall32_no_wreq_when_full", viol, 0);

        // sync_clr after the phase-1 word of 24bpp
        ctrl_cd = 2'd2;
        clr();
        push_word(32'hAABBCCDD, waits);
        push_word(32'hEEFF0011, waits);
        idle();
        exp_q.push_back(24'hAABBCC);
        exp_q.push_back(24'hDDEEFF);
        expect_stream("pre_clr");
        @(negedge clk);
        sync_clr    = 1'b1;
        dat_valid_i = 1'b1;
        dat_i       = 32'hDEADBEEF;
        #1 chk("clr_blocks_accept", dat_ready_o, 0);
        @(negedge clk);
        sync_clr    = 1'b0;
        dat_valid_i = 1'b0;
        push_word(32'h010203FF, waits);
        push_word(32'h04050607, waits);
        idle();
        exp_q.push_back(24'h010203);
        exp_q.push_back(24'hFF0405);
        expect_stream("post_clr");

        // Randomized words and FIFO-full pattern against the reference
        for (int r = 0; r < 8; r++) begin
            ctrl_cd = 2'(r % 4);
            clr();
            wq.delete();
            for (int i = 0; i < 6; i++) wq.push_back($urandom());
            build_exp(2'(r % 4));
            rand_full_en = 1'b1;
            foreach (wq[i]) begin
                push_word(wq[i], waits);
                if ($urandom_range(0, 3) == 0) idle();
            end
            idle();
            expect_stream($sformatf("rand%0d", r));
            rand_full_en = 1'b0;
            chk($sformatf("rand%0d_no_wreq_when_full", r), viol, 0);
        end

        // Reset in the middle of an 8bpp word
        ctrl_cd = 2'd0;
        clr();
        push_word(32'hAABBCCDD, waits);
        idle();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_wreq", pix_wreq_o, 0);
        chk("midrst_pix", pix_o, 0);
        chk("midrst_ready", dat_ready_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        got_q.delete();
        stamp_q.delete();
        push_word(32'h01020304, waits);
        idle();
        wq.delete();
        wq.push_back(32'h01020304);
        build_exp(2'd0);
        expect_stream("post_rst");

`ifdef VGA_PIXUNPACK_CLUT_EN
        // Pseudo-colour lookups, ack two cycles into each request
        ctrl_cd = 2'd0;
        ctrl_pc = 1'b1;
        clr();
        exp_q.push_back(clut_of(8'h05));
        exp_q.push_back(clut_of(8'h06));
        exp_q.push_back(clut_of(8'h00));
        exp_q.push_back(clut_of(8'h00));
        fork
            begin
                push_word(32'h05060000, waits);
                idle();
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    n = 0;
                    while (!clut_req_o && n < 50) begin
                        @(negedge clk);
                        n++;
                    end
                    chk($sformatf("clut_adr%0d", k), clut_adr_o, (k == 0) ? 8'h05 : (k == 1) ? 8'h06 : 8'h00);
                    @(negedge clk);
                    clut_q_i   = clut_of(clut_adr_o);
                    clut_ack_i = 1'b1;
                    @(negedge clk);
                    clut_ack_i = 1'b0;
                    chk($sformatf("clut_wreq%0d", k), pix_wreq_o, 1);
                end
            end
        join
        expect_stream("clut");
        ctrl_pc = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
